mem_lsu: RTL

- Load/store initiator that sits between the MIPS datapath and the word-organised data RAM.
- Accepts one byte, halfword or word request at a time and drives the RAM's address, write-data, write-enable and read-enable.
- Performs read-modify-write for sub-word stores, and extracts plus sign- or zero-extends sub-word loads.
- Flags misaligned, illegal-size and out-of-range accesses without touching the RAM.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/lane_align.sv | 41 ++++
 rtl/mem_lsu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and the request legality check for the load/store unit.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // True when the request must be rejected without touching the RAM.
  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int          depth);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (size == 2'b11)
        || (size == SZ_HALF && addr[0])
        || (size == SZ_WORD && addr[1:0] != 2'b00)
        || (word_idx >= 32'(depth));
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane extraction with sign/zero extension, and sub-word store merge.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [LANE_W-1:0]   byte_lane;
  logic [2*LANE_W-1:0] half_lane;
  logic [4:0]          byte_shift;
  logic [4:0]          half_shift;

  always_comb begin
    byte_shift = {addr_lo, 3'b000};
    half_shift = {addr_lo[1], 4'b0000};
    byte_lane  = word[byte_shift +: LANE_W];
    half_lane  = word[half_shift +: 2*LANE_W];
    load_data  = word;
    store_word = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{(32-LANE_W){~is_unsigned & byte_lane[LANE_W-1]}}, byte_lane};
        store_word[byte_shift +: LANE_W] = wdata[LANE_W-1:0];
      end
      SZ_HALF: begin
        load_data = {{(32-2*LANE_W){~is_unsigned & half_lane[2*LANE_W-1]}}, half_lane};
        store_word[half_shift +: 2*LANE_W] = wdata[2*LANE_W-1:0];
      end
      default: begin
        store_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Single-outstanding load/store initiator for a word-organised RAM; all outputs registered,
// sub-word stores are done as read-modify-write.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [31:0]           ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_write,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  state_t      state_reg, state_next;
  logic [1:0]  addr_lo_reg, addr_lo_next;
  logic [1:0]  size_reg, size_next;
  logic        write_reg, write_next;
  logic        unsigned_reg, unsigned_next;
  logic [31:0] wdata_reg, wdata_next;

  logic        req_ready_reg, req_ready_next;
  logic        resp_valid_reg, resp_valid_next;
  logic [31:0] resp_rdata_reg, resp_rdata_next;
  logic        resp_error_reg, resp_error_next;
  logic [31:0] ram_address_reg, ram_address_next;
  logic [31:0] ram_data_write_reg, ram_data_write_next;
  logic        ram_write_en_reg, ram_write_en_next;
  logic        ram_read_en_reg, ram_read_en_next;

  logic [31:0] load_data;
  logic [31:0] merged_word;

  lane_align u_lane_align (
    .word        (ram_data_out),
    .addr_lo     (addr_lo_reg),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .wdata       (wdata_reg),
    .load_data   (load_data),
    .store_word  (merged_word)
  );

  always_comb begin
    state_next          = state_reg;
    addr_lo_next        = addr_lo_reg;
    size_next           = size_reg;
    write_next          = write_reg;
    unsigned_next       = unsigned_reg;
    wdata_next          = wdata_reg;
    ram_address_next    = ram_address_reg;
    ram_data_write_next = ram_data_write_reg;
    resp_rdata_next     = '0;
    resp_error_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_lo_next  = req_addr[1:0];
          size_next     = req_size;
          write_next    = req_write;
          unsigned_next = req_unsigned;
          wdata_next    = req_wdata;
          if (access_error(req_size, req_addr, DEPTH)) begin
            state_next      = RESP;
            resp_error_next = 1'b1;
          end else begin
            ram_address_next = {req_addr[31:2], 2'b00};
            // A full-word store has nothing to preserve, so it skips the read.
            if (req_write && req_size == SZ_WORD) begin
              state_next          = WR;
              ram_data_write_next = req_wdata;
            end else begin
              state_next = RD;
            end
          end
        end
      end
      RD: begin
        if (write_reg) begin
          state_next          = WR;
          ram_data_write_next = merged_word;
        end else begin
          state_next      = RESP;
          resp_rdata_next = load_data;
        end
      end
      WR:      state_next = RESP;
      default: state_next = IDLE;
    endcase

    req_ready_next    = (state_next == IDLE);
    ram_read_en_next  = (state_next == RD);
    ram_write_en_next = (state_next == WR);
    resp_valid_next   = (state_next == RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= IDLE;
      addr_lo_reg        <= '0;
      size_reg           <= '0;
      write_reg          <= 1'b0;
      unsigned_reg       <= 1'b0;
      wdata_reg          <= '0;
      req_ready_reg      <= 1'b1;
      resp_valid_reg     <= 1'b0;
      resp_rdata_reg     <= '0;
      resp_error_reg     <= 1'b0;
      ram_address_reg    <= '0;
      ram_data_write_reg <= '0;
      ram_write_en_reg   <= 1'b0;
      ram_read_en_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      addr_lo_reg        <= addr_lo_next;
      size_reg           <= size_next;
      write_reg          <= write_next;
      unsigned_reg       <= unsigned_next;
      wdata_reg          <= wdata_next;
      req_ready_reg      <= req_ready_next;
      resp_valid_reg     <= resp_valid_next;
      resp_rdata_reg     <= resp_rdata_next;
      resp_error_reg     <= resp_error_next;
      ram_address_reg    <= ram_address_next;
      ram_data_write_reg <= ram_data_write_next;
      ram_write_en_reg   <= ram_write_en_next;
      ram_read_en_reg    <= ram_read_en_next;
    end
  end

  assign req_ready      = req_ready_reg;
  assign resp_valid     = resp_valid_reg;
  assign resp_rdata     = resp_rdata_reg;
  assign resp_error     = resp_error_reg;
  assign ram_address    = ram_address_reg;
  assign ram_data_write = ram_data_write_reg;
  assign ram_write_en   = ram_write_en_reg;
  assign ram_read_en    = ram_read_en_reg;

endmodule
